// File: rtl/game_pkg.sv
// Shared codes and enums for the m,n,k-game engine.
package game_pkg;

   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] PX    = 2'b01;
   localparam logic [1:0] PO    = 2'b10;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_X    = 2'b01;
   localparam logic [1:0] WIN_O    = 2'b10;

   typedef enum logic [1:0] {
      DIR_H = 2'd0,
      DIR_V = 2'd1,
      DIR_D = 2'd2,
      DIR_A = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   function automatic logic [1:0] other_player(input logic [1:0] p);
      return (p == PX) ? PO : PX;
   endfunction

endpackage

// File: rtl/mnk_game_engine_if.sv
// Move handshake, game control and status bundle between a controller and the engine.
interface mnk_game_engine_if #(
   parameter int N = 3
);
   logic               new_game;
   logic [3:0]         x_in;
   logic [3:0]         y_in;
   logic               move_valid;
   logic               move_ready;
   logic               move_illegal;
   logic [1:0]         current_player;
   logic [1:0]         winner;
   logic               tie;
   logic               game_over;
   logic [2*N*N-1:0]   board;

   modport master (
      output new_game, x_in, y_in, move_valid,
      input  move_ready, move_illegal, current_player, winner, tie, game_over, board
   );

   modport slave (
      input  new_game, x_in, y_in, move_valid,
      output move_ready, move_illegal, current_player, winner, tie, game_over, board
   );
endinterface

// File: rtl/mnk_run_count.sv
// Length of the run of one player's stones through a cell along one direction,
// counting both sides, each side capped at K-1 and stopped at the board edge.
module mnk_run_count
   import game_pkg::*;
#(
   parameter int N = 3,
   parameter int K = 3
) (
   input  logic [2*N*N-1:0] board,
   input  logic [3:0]       row,
   input  logic [3:0]       col,
   input  dir_t             dir,
   input  logic [1:0]       player,
   output logic [3:0]       run_len
);

   // Off-board positions read as EMPTY, which never matches a player code.
   function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] b, input int r, input int c);
      logic [2*N*N-1:0] sh;
      if (r < 0 || r >= N || c < 0 || c >= N) return EMPTY;
      sh = b >> (2 * (N*N - 1 - (r*N + c)));
      return sh[1:0];
   endfunction

   always_comb begin
      int   dr;
      int   dc;
      int   len;
      logic go_pos;
      logic go_neg;
      // NOTE: every local gets a value before use so no state is held between evaluations.
      dr     = 0;
      dc     = 1;
      len    = 1;
      go_pos = 1'b1;
      go_neg = 1'b1;
      case (dir)
         DIR_H:   begin dr = 0; dc =  1; end
         DIR_V:   begin dr = 1; dc =  0; end
         DIR_D:   begin dr = 1; dc =  1; end
         default: begin dr = 1; dc = -1; end
      endcase
      for (int i = 1; i < K; i++) begin
         if (go_pos && cell_at(board, int'(row) + i*dr, int'(col) + i*dc) == player) len++;
         else go_pos = 1'b0;
         if (go_neg && cell_at(board, int'(row) - i*dr, int'(col) - i*dc) == player) len++;
         else go_neg = 1'b0;
      end
      run_len = 4'(len);
   end

endmodule

// File: rtl/mnk_game_engine.sv
// m,n,k-game referee: validates moves, keeps the board and checks for a win in
// four single-direction scan cycles after every accepted move.
module mnk_game_engine
   import game_pkg::*;
#(
   parameter int N         = 3,
   parameter int K         = 3,
   parameter bit ALT_START = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   mnk_game_engine_if.slave  bus
);

   localparam int CELLS = N * N;
   localparam int CW    = $clog2(CELLS + 1);

   state_t             state;
   dir_t               dir;
   logic [2*CELLS-1:0] board;
   logic [CW-1:0]      count;
   logic [3:0]         last_row;
   logic [3:0]         last_col;
   logic [1:0]         current_player;
   logic [1:0]         start_player;
   logic [1:0]         winner;
   logic               tie;
   logic               won;
   logic               move_ready;
   logic               move_illegal;

   logic               coord_ok;
   logic               cell_free;
   logic               accept;
   int                 cell_idx;
   logic [3:0]         run_len;
   logic               hit;
   logic [1:0]         next_start;

   always_comb begin
      coord_ok  = (bus.x_in < 4'(N)) && (bus.y_in < 4'(N));
      cell_idx  = coord_ok ? int'(bus.x_in) * N + int'(bus.y_in) : 0;
      cell_free = (2'(board >> (2 * (CELLS - 1 - cell_idx))) == EMPTY);
      accept    = bus.move_valid && move_ready;
      hit       = (run_len >= 4'(K));
      next_start = (ALT_START && start_player == PX) ? PO : PX;
   end

   mnk_run_count #(.N(N), .K(K)) u_run_count (
      .board   (board),
      .row     (last_row),
      .col     (last_col),
      .dir     (dir),
      .player  (current_player),
      .run_len (run_len)
   );

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         dir            <= DIR_H;
         board          <= '0;
         count          <= '0;
         last_row       <= '0;
         last_col       <= '0;
         current_player <= PX;
         start_player   <= PX;
         winner         <= WIN_NONE;
         tie            <= 1'b0;
         won            <= 1'b0;
         move_ready     <= 1'b1;
         move_illegal   <= 1'b0;
      end else if (bus.new_game) begin
         state          <= ST_IDLE;
         dir            <= DIR_H;
         board          <= '0;
         count          <= '0;
         current_player <= next_start;
         start_player   <= next_start;
         winner         <= WIN_NONE;
         tie            <= 1'b0;
         won            <= 1'b0;
         move_ready     <= 1'b1;
         move_illegal   <= 1'b0;
      end else begin
         move_illegal <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (coord_ok && cell_free) begin
                     for (int k = 0; k < CELLS; k++)
                        if (k == cell_idx) board[2*(CELLS-1-k) +: 2] <= current_player;
                     count      <= count + CW'(1);
                     last_row   <= bus.x_in;
                     last_col   <= bus.y_in;
                     dir        <= DIR_H;
                     won        <= 1'b0;
                     move_ready <= 1'b0;
                     state      <= ST_SCAN;
                  end else begin
                     move_illegal <= 1'b1;
                  end
               end
            end
            ST_SCAN: begin
               if (dir == DIR_A) begin
                  move_ready <= 1'b1;
                  if (won || hit) begin
                     winner <= current_player;
                     state  <= ST_OVER;
                  end else if (count == CW'(CELLS)) begin
                     tie   <= 1'b1;
                     state <= ST_OVER;
                  end else begin
                     current_player <= other_player(current_player);
                     state          <= ST_IDLE;
                  end
               end else begin
                  won <= won | hit;
                  dir <= dir_t'(dir + 2'd1);
               end
            end
            ST_OVER: begin
               if (accept) move_illegal <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.move_ready     = move_ready;
   assign bus.move_illegal   = move_illegal;
   assign bus.current_player = current_player;
   assign bus.winner         = winner;
   assign bus.tie            = tie;
   assign bus.game_over      = (winner != WIN_NONE) || tie;
   assign bus.board          = board;

endmodule

// File: tb/tb_mnk_game_engine.sv
// Directed bench: engines A (3,3,fixed start), B (5,4) and C (3,3,alternating start)
// driven from a table of moves with hand-computed outcomes plus a few timed sequences.
module tb_mnk_game_engine;
   import game_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       new_game = 1'b0;
   logic       valid_a = 1'b0;
   logic       valid_b = 1'b0;
   logic [3:0] x = '0;
   logic [3:0] y = '0;
   int         checks = 0;
   int         errors = 0;
   logic [1:0] c_start = PX;

   always #5 clk = ~clk;

   mnk_game_engine_if #(.N(3)) bus_a ();
   mnk_game_engine_if #(.N(5)) bus_b ();
   mnk_game_engine_if #(.N(3)) bus_c ();

   assign bus_a.new_game = new_game;
   assign bus_a.x_in = x;
   assign bus_a.y_in = y;
   assign bus_a.move_valid = valid_a;
   assign bus_b.new_game = new_game;
   assign bus_b.x_in = x;
   assign bus_b.y_in = y;
   assign bus_b.move_valid = valid_b;
   assign bus_c.new_game = new_game;
   assign bus_c.x_in = x;
   assign bus_c.y_in = y;
   assign bus_c.move_valid = valid_a;

   mnk_game_engine #(.N(3), .K(3), .ALT_START(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   mnk_game_engine #(.N(5), .K(4), .ALT_START(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
   mnk_game_engine #(.N(3), .K(3), .ALT_START(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

   typedef struct {
      logic       ng;      // pulse new_game before this move
      logic       b;       // 1: move goes to engine B, else to A (and C)
      logic [3:0] x;
      logic [3:0] y;
      logic       ill;
      logic [1:0] player;  // expected current_player once the move has settled
      logic [1:0] winner;
      logic       tie;
   } vec_t;

   vec_t vecs [29];

   function automatic vec_t mk(input logic ng, input logic b, input int xi, input int yi,
                               input logic ill, input logic [1:0] pl, input logic [1:0] wn,
                               input logic t);
      vec_t v;
      v.ng = ng; v.b = b; v.x = 4'(xi); v.y = 4'(yi);
      v.ill = ill; v.player = pl; v.winner = wn; v.tie = t;
      return v;
   endfunction

   function automatic logic [63:0] put(input logic [63:0] bv, input int n, input int r,
                                       input int c, input logic [1:0] p);
      logic [63:0] o;
      o = bv;
      o[2*(n*n-1-(r*n+c)) +: 2] = p;
      return o;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sample(input logic b, output logic ill, output logic rdy, output logic [1:0] pl,
                         output logic [1:0] wn, output logic t, output logic ov);
      if (b) begin
         ill = bus_b.move_illegal; rdy = bus_b.move_ready; pl = bus_b.current_player;
         wn = bus_b.winner; t = bus_b.tie; ov = bus_b.game_over;
      end else begin
         ill = bus_a.move_illegal; rdy = bus_a.move_ready; pl = bus_a.current_player;
         wn = bus_a.winner; t = bus_a.tie; ov = bus_a.game_over;
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      logic ill, rdy, t, ov;
      logic [1:0] pl, wn;
      int budget;
      @(negedge clk);
      sample(v.b, ill, rdy, pl, wn, t, ov);
      budget = 0;
      while (!rdy && budget < 16) begin
         @(negedge clk);
         sample(v.b, ill, rdy, pl, wn, t, ov);
         budget++;
      end
      if (!rdy) check({tag, "_ready_wait"}, rdy, 1'b1);
      x = v.x; y = v.y;
      if (v.b) valid_b = 1'b1; else valid_a = 1'b1;
      @(posedge clk); #1;
      valid_a = 1'b0; valid_b = 1'b0;
      sample(v.b, ill, rdy, pl, wn, t, ov);
      check({tag, "_illegal"}, ill, v.ill);
      if (v.ill) begin
         @(posedge clk); #1;
         sample(v.b, ill, rdy, pl, wn, t, ov);
         check({tag, "_pulse_end"}, ill, 1'b0);
      end else begin
         check({tag, "_busy_first"}, rdy, 1'b0);
         repeat (3) @(posedge clk);
         #1;
         sample(v.b, ill, rdy, pl, wn, t, ov);
         check({tag, "_busy_last"}, rdy, 1'b0);
         @(posedge clk); #1;
         sample(v.b, ill, rdy, pl, wn, t, ov);
         check({tag, "_ready_back"}, rdy, 1'b1);
      end
      check({tag, "_player"}, pl, v.player);
      check({tag, "_winner"}, wn, v.winner);
      check({tag, "_tie"}, t, v.tie);
      check({tag, "_game_over"}, ov, (v.winner != WIN_NONE) || v.tie);
   endtask

   task automatic do_new_game(input string tag);
      @(negedge clk);
      new_game = 1'b1;
      @(posedge clk); #1;
      new_game = 1'b0;
      c_start = (c_start == PX) ? PO : PX;
      check({tag, "_ng_board"}, bus_a.board, 64'd0);
      check({tag, "_ng_player"}, bus_a.current_player, PX);
      check({tag, "_ng_winner"}, bus_a.winner, WIN_NONE);
      check({tag, "_ng_tie"}, bus_a.tie, 1'b0);
      check({tag, "_ng_ready"}, bus_a.move_ready, 1'b1);
      check({tag, "_ng_c_player"}, bus_c.current_player, c_start);
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (vecs[i].ng) do_new_game($sformatf("v%0d", i));
         apply(vecs[i], $sformatf("v%0d", i));
      end
   endtask

   task automatic mid_scan_new_game(input string tag);
      @(negedge clk);
      x = 4'd0; y = 4'd0; valid_a = 1'b1;
      @(posedge clk); #1;
      valid_a = 1'b0;
      check({tag, "_in_scan"}, bus_a.move_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      new_game = 1'b1;
      @(posedge clk); #1;
      new_game = 1'b0;
      c_start = (c_start == PX) ? PO : PX;
      check({tag, "_board"}, bus_a.board, 64'd0);
      check({tag, "_ready"}, bus_a.move_ready, 1'b1);
      check({tag, "_winner"}, bus_a.winner, WIN_NONE);
      check({tag, "_player"}, bus_a.current_player, PX);
      check({tag, "_c_player"}, bus_c.current_player, c_start);
      repeat (5) @(posedge clk);
      #1;
      check({tag, "_settled_player"}, bus_a.current_player, PX);
      check({tag, "_settled_ready"}, bus_a.move_ready, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] exp_bd;

      vecs[0]  = mk(0, 0, 0, 0, 0, PO, WIN_NONE, 0);
      vecs[1]  = mk(0, 0, 1, 0, 0, PX, WIN_NONE, 0);
      vecs[2]  = mk(0, 0, 0, 1, 0, PO, WIN_NONE, 0);
      vecs[3]  = mk(0, 0, 1, 1, 0, PX, WIN_NONE, 0);
      vecs[4]  = mk(0, 0, 0, 2, 0, PX, WIN_X,    0);
      vecs[5]  = mk(0, 0, 1, 2, 1, PX, WIN_X,    0);
      vecs[6]  = mk(1, 0, 3, 0, 1, PX, WIN_NONE, 0);
      vecs[7]  = mk(0, 0, 0, 3, 1, PX, WIN_NONE, 0);
      vecs[8]  = mk(0, 0, 1, 1, 0, PO, WIN_NONE, 0);
      vecs[9]  = mk(0, 0, 1, 1, 1, PO, WIN_NONE, 0);
      vecs[10] = mk(1, 0, 0, 0, 0, PO, WIN_NONE, 0);
      vecs[11] = mk(0, 0, 0, 1, 0, PX, WIN_NONE, 0);
      vecs[12] = mk(0, 0, 0, 2, 0, PO, WIN_NONE, 0);
      vecs[13] = mk(0, 0, 1, 1, 0, PX, WIN_NONE, 0);
      vecs[14] = mk(0, 0, 1, 0, 0, PO, WIN_NONE, 0);
      vecs[15] = mk(0, 0, 1, 2, 0, PX, WIN_NONE, 0);
      vecs[16] = mk(0, 0, 2, 1, 0, PO, WIN_NONE, 0);
      vecs[17] = mk(0, 0, 2, 0, 0, PX, WIN_NONE, 0);
      vecs[18] = mk(0, 0, 2, 2, 0, PX, WIN_NONE, 1);
      vecs[19] = mk(0, 0, 0, 0, 1, PX, WIN_NONE, 1);
      vecs[20] = mk(0, 1, 4, 4, 0, PO, WIN_NONE, 0);
      vecs[21] = mk(0, 1, 0, 3, 0, PX, WIN_NONE, 0);
      vecs[22] = mk(0, 1, 4, 3, 0, PO, WIN_NONE, 0);
      vecs[23] = mk(0, 1, 2, 1, 0, PX, WIN_NONE, 0);
      vecs[24] = mk(0, 1, 0, 0, 0, PO, WIN_NONE, 0);
      vecs[25] = mk(0, 1, 3, 0, 0, PX, WIN_NONE, 0);
      vecs[26] = mk(0, 1, 4, 0, 0, PO, WIN_NONE, 0);
      vecs[27] = mk(0, 1, 1, 2, 0, PO, WIN_O,    0);
      vecs[28] = mk(0, 1, 2, 2, 1, PO, WIN_O,    0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_board", bus_a.board, 64'd0);
      check("rst_ready", bus_a.move_ready, 1'b1);
      check("rst_illegal", bus_a.move_illegal, 1'b0);
      check("rst_player", bus_a.current_player, PX);
      check("rst_winner", bus_a.winner, WIN_NONE);
      check("rst_tie", bus_a.tie, 1'b0);
      check("rst_game_over", bus_a.game_over, 1'b0);
      check("rst_b_player", bus_b.current_player, PX);
      check("rst_c_player", bus_c.current_player, PX);

      // Row-0 win for X, then a rejected move in the finished game.
      run_range(0, 5);
      exp_bd = '0;
      exp_bd = put(exp_bd, 3, 0, 0, PX);
      exp_bd = put(exp_bd, 3, 0, 1, PX);
      exp_bd = put(exp_bd, 3, 0, 2, PX);
      exp_bd = put(exp_bd, 3, 1, 0, PO);
      exp_bd = put(exp_bd, 3, 1, 1, PO);
      check("win_board", bus_a.board, exp_bd);

      // Off-board coordinates and an occupied cell.
      run_range(6, 9);
      exp_bd = put(64'd0, 3, 1, 1, PX);
      check("occupied_board", bus_a.board, exp_bd);

      // Full board with no line.
      run_range(10, 19);

      // 5x5, K=4: O completes the anti-diagonal from the middle of the run.
      run_range(20, 28);
      exp_bd = '0;
      exp_bd = put(exp_bd, 5, 4, 4, PX);
      exp_bd = put(exp_bd, 5, 0, 3, PO);
      exp_bd = put(exp_bd, 5, 4, 3, PX);
      exp_bd = put(exp_bd, 5, 2, 1, PO);
      exp_bd = put(exp_bd, 5, 0, 0, PX);
      exp_bd = put(exp_bd, 5, 3, 0, PO);
      exp_bd = put(exp_bd, 5, 4, 0, PX);
      exp_bd = put(exp_bd, 5, 1, 2, PO);
      check("b_board", bus_b.board, exp_bd);

      do_new_game("pre_mid");
      mid_scan_new_game("mid0");
      mid_scan_new_game("mid1");
      check("mid1_c_is_o", bus_c.current_player, PO);
      apply(mk(0, 0, 0, 0, 0, PO, WIN_NONE, 0), "after_mid");

      // Reset wins over a coincident new_game and move.
      @(negedge clk);
      rst = 1'b1; new_game = 1'b1; valid_a = 1'b1; x = 4'd1; y = 4'd1;
      @(posedge clk); #1;
      rst = 1'b0; new_game = 1'b0; valid_a = 1'b0;
      c_start = PX;
      check("rst_over_board", bus_a.board, 64'd0);
      check("rst_over_player", bus_a.current_player, PX);
      check("rst_over_c_player", bus_c.current_player, c_start);
      check("rst_over_b_board", bus_b.board, 64'd0);
      check("rst_over_ready", bus_a.move_ready, 1'b1);
      @(posedge clk); #1;
      check("rst_over_no_move", bus_a.board, 64'd0);
      check("rst_over_illegal", bus_a.move_illegal, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
